// File: rtl/reorder_fifo_ctrl.sv
// Reorder buffer between in-order dispatch push and in-order commit pop.
// Ports: CLK/RST, dispatch push vld/data/rdy, commit head/empty/pop, abort/flush_busy, entry_cnt.
// Optional statistics outputs when REORDER_FIFO_STAT_EN is defined.
module reorder_fifo_ctrl #(
    parameter int DW        = 77,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int FLUSH_CYC = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          dispatch_push_vld,
    input  logic [DW-1:0] dispatch_push_data,
    output logic          dispatch_push_rdy,
    output logic [DW-1:0] commit_fifo,
    output logic          reOrder_fifo_empty,
    input  logic          reOrder_fifo_pop,
    input  logic          commit_abort,
    output logic          flush_busy,
    output logic [AW:0]   entry_cnt
`ifdef REORDER_FIFO_STAT_EN
    ,
    output logic [31:0]   stat_push_cnt,
    output logic [31:0]   stat_flush_cnt,
    output logic [31:0]   stat_full_cyc
`endif
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   entryCnt;
    logic [0:0]    state;
    logic [3:0]    drainCnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          popOk;

    assign full  = (entryCnt == (AW+1)'(DEPTH));
    assign empty = (entryCnt == '0);

    assign dispatch_push_rdy = (state == RUN) & ~full & ~commit_abort & ~RST;
    assign push  = dispatch_push_vld & dispatch_push_rdy;
    assign popOk = reOrder_fifo_pop & ~empty & ~commit_abort;

    // Report empty/idle while reset is held, even before the first edge.
    assign reOrder_fifo_empty = empty | RST;
    assign flush_busy         = (state == FLUSH) & ~RST;
    assign commit_fifo        = mem[rdPtr];
    assign entry_cnt          = entryCnt;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wrPtr] <= dispatch_push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            entryCnt <= '0;
            state    <= RUN;
            drainCnt <= '0;
        end else if (commit_abort) begin
            // Abort discards everything, also when already draining.
            wrPtr    <= '0;
            rdPtr    <= '0;
            entryCnt <= '0;
            state    <= FLUSH;
            drainCnt <= 4'(FLUSH_CYC - 1);
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (popOk) begin
                rdPtr <= rdPtr + AW'(1);
            end
            unique case ({push, popOk})
                2'b10:   entryCnt <= entryCnt + (AW+1)'(1);
                2'b01:   entryCnt <= entryCnt - (AW+1)'(1);
                default: entryCnt <= entryCnt;
            endcase
            if (state == FLUSH) begin
                if (drainCnt == '0) begin
                    state <= RUN;
                end else begin
                    drainCnt <= drainCnt - 4'd1;
                end
            end
        end
    end

`ifdef REORDER_FIFO_STAT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_push_cnt  <= '0;
            stat_flush_cnt <= '0;
            stat_full_cyc  <= '0;
        end else begin
            if (push && stat_push_cnt != '1) begin
                stat_push_cnt <= stat_push_cnt + 32'd1;
            end
            if (commit_abort && state == RUN && stat_flush_cnt != '1) begin
                stat_flush_cnt <= stat_flush_cnt + 32'd1;
            end
            if (full && dispatch_push_vld && stat_full_cyc != '1) begin
                stat_full_cyc <= stat_full_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_fifo_ctrl.sv
// Self-checking bench for reorder_fifo_ctrl: vector table plus scoreboard sequences.
// Scoreboard queue holds expected head order; compared when commit pops.
module tb_reorder_fifo_ctrl;

    localparam int DW    = 77;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FC    = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          vld;
    logic [DW-1:0] data;
    logic          rdy;
    logic [DW-1:0] head;
    logic          empty;
    logic          pop;
    logic          abort;
    logic          busy;
    logic [AW:0]   cnt;
`ifdef REORDER_FIFO_STAT_EN
    logic [31:0]   statPush;
    logic [31:0]   statFlush;
    logic [31:0]   statFull;
`endif

    int tests  = 0;
    int failed = 0;
    logic [DW-1:0] sb[$];

    always #5 CLK = ~CLK;

    reorder_fifo_ctrl #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .FLUSH_CYC(FC)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .dispatch_push_vld  (vld),
        .dispatch_push_data (data),
        .dispatch_push_rdy  (rdy),
        .commit_fifo        (head),
        .reOrder_fifo_empty (empty),
        .reOrder_fifo_pop   (pop),
        .commit_abort       (abort),
        .flush_busy         (busy),
        .entry_cnt          (cnt)
`ifdef REORDER_FIFO_STAT_EN
        ,
        .stat_push_cnt      (statPush),
        .stat_flush_cnt     (statFlush),
        .stat_full_cyc      (statFull)
`endif
    );

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic          pop;
        logic          expRdy;
        logic          expEmpty;
        logic [AW:0]   expCnt;
        logic          chkHead;
        logic [DW-1:0] expHead;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic doReset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, b, c;
        int low;
        int maxCnt;
        a = 77'h0_1000_0000_0000_0AAA;
        b = 77'h0_2000_0000_0000_0BBB;
        c = 77'h0_3000_0000_0000_0CCC;
        //          vld data pop rdy emp cnt chk head
        vecs[0] = '{1'b1, a,  1'b0, 1'b1, 1'b1, 5'd0, 1'b0, '0};
        vecs[1] = '{1'b1, b,  1'b0, 1'b1, 1'b0, 5'd1, 1'b1, a};
        vecs[2] = '{1'b1, c,  1'b0, 1'b1, 1'b0, 5'd2, 1'b1, a};
        vecs[3] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, a};
        vecs[4] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, a};
        vecs[5] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, b};
        vecs[6] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, c};
        vecs[7] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, '0};
        vecs[8] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, '0};

        vld   = 1'b1;
        data  = '0;
        pop   = 1'b0;
        abort = 1'b0;
        RST   = 1'b1;
        tick();
        tick();
        chk("rst_empty", DW'(empty), DW'(1));
        chk("rst_rdy",   DW'(rdy),   DW'(0));
        chk("rst_busy",  DW'(busy),  DW'(0));
        vld = 1'b0;
        RST = 1'b0;
        #1;
        chk("rst_cnt",   DW'(cnt),   DW'(0));
        chk("rst_empty2", DW'(empty), DW'(1));

        // Tests 1 and 2: push A,B,C then pop with a 4th ignored pop.
        for (int i = 0; i < 9; i++) begin
            vld  = vecs[i].vld;
            data = vecs[i].data;
            pop  = vecs[i].pop;
            #1;
            chk($sformatf("v%0d_rdy", i), DW'(rdy), DW'(vecs[i].expRdy));
            chk($sformatf("v%0d_empty", i), DW'(empty),
                DW'(vecs[i].expEmpty));
            chk($sformatf("v%0d_cnt", i), DW'(cnt), DW'(vecs[i].expCnt));
            chk($sformatf("v%0d_busy", i), DW'(busy), DW'(0));
            if (vecs[i].chkHead) begin
                chk($sformatf("v%0d_head", i), head, vecs[i].expHead);
            end
            tick();
        end
        vld = 1'b0;
        pop = 1'b0;

        // Test 3: full, then push+pop together.
        for (int i = 0; i < DEPTH; i++) begin
            vld  = 1'b1;
            data = rnd();
            sb.push_back(data);
            tick();
        end
        vld = 1'b0;
        #1;
        chk("full_cnt", DW'(cnt), DW'(16));
        chk("full_rdy", DW'(rdy), DW'(0));
        vld  = 1'b1;
        pop  = 1'b1;
        data = rnd();
        #1;
        chk("full_pp_rdy", DW'(rdy), DW'(0));
        chk("full_pp_head", head, sb[0]);
        tick();
        void'(sb.pop_front());
        vld = 1'b0;
        pop = 1'b0;
        #1;
        chk("full_pp_cnt", DW'(cnt), DW'(15));
        chk("full_pp_rdy2", DW'(rdy), DW'(1));
        pop = 1'b1;
        while (sb.size() > 0) begin
            #1;
            chk("drain_head", head, sb[0]);
            tick();
            void'(sb.pop_front());
        end
        pop = 1'b0;
        #1;
        chk("drain_empty", DW'(empty), DW'(1));

        // Test 4: fill 5, then push with abort.
        for (int i = 0; i < 5; i++) begin
            vld  = 1'b1;
            data = rnd();
            tick();
        end
        chk("ab_pre_cnt", DW'(cnt), DW'(5));
        data  = rnd();
        abort = 1'b1;
        #1;
        chk("ab_rdy", DW'(rdy), DW'(0));
        tick();
        abort = 1'b0;
        #1;
        chk("ab_cnt", DW'(cnt), DW'(0));
        chk("ab_empty", DW'(empty), DW'(1));
        chk("ab_busy", DW'(busy), DW'(1));
        low = 0;
        while (!rdy && low < 10) begin
            low++;
            tick();
        end
        chk("ab_window", DW'(low), DW'(FC));
        chk("ab_cnt_after", DW'(cnt), DW'(0));
        vld = 1'b0;
        sb.delete();

        // Test 5: second abort during drain restarts the window.
        abort = 1'b1;
        tick();
        #1;
        chk("ab2_busy", DW'(busy), DW'(1));
        chk("ab2_rdy", DW'(rdy), DW'(0));
        tick();
        abort = 1'b0;
        vld   = 1'b1;
        #1;
        low = 0;
        while (!rdy && low < 10) begin
            low++;
            tick();
        end
        chk("ab2_window", DW'(low), DW'(FC));
        chk("ab2_busy_end", DW'(busy), DW'(0));
        vld = 1'b0;

        // Test 6: 40 push/pop pairs across pointer wrap.
        doReset();
        maxCnt = 0;
        for (int i = 0; i <= 40; i++) begin
            vld  = (i < 40);
            pop  = (i > 0);
            data = rnd();
            #1;
            if (pop) begin
                chk($sformatf("wrap%0d_head", i), head, sb[0]);
            end
            chk($sformatf("wrap%0d_cnt", i), DW'(cnt), DW'(sb.size()));
            if (int'(cnt) > maxCnt) begin
                maxCnt = int'(cnt);
            end
            tick();
            if (pop) begin
                void'(sb.pop_front());
            end
            if (vld) begin
                sb.push_back(data);
            end
        end
        vld = 1'b0;
        pop = 1'b0;
        #1;
        chk("wrap_range", DW'(maxCnt <= 16), DW'(1));
        chk("wrap_empty", DW'(empty), DW'(1));
`ifdef REORDER_FIFO_STAT_EN
        chk("stat_push", DW'(statPush), DW'(40));
        chk("stat_flush", DW'(statFlush), DW'(0));
        chk("stat_full", DW'(statFull), DW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
